// File: rtl/mt9d111_pkg.sv
// mt9d111_pkg: shared state encoding and default frame geometry for the MT9D111 frame writer
package mt9d111_pkg;
  localparam int H_PIXELS_DEF = 800;
  localparam int V_LINES_DEF = 600;
  localparam int BYTES_PER_PIXEL_DEF = 4;
  typedef enum logic [1:0] {WAIT_INIT, WAIT_SOF, CAPTURE, HOLD} state_t;
endpackage

// File: rtl/mt9d111_pulse_edge.sv
// mt9d111_pulse_edge: rising-edge detector, one pulse per low-to-high transition
module mt9d111_pulse_edge (
  input  logic aclk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);
  logic sig_q;
  // previous-cycle sample of the input
  always_ff @(posedge aclk or posedge reset)
    if (reset) sig_q <= 1'b0;
    else sig_q <= sig_i;
  assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/mt9d111_frame_wr_ctrl.sv
// mt9d111_frame_wr_ctrl: writes camera pixels to a frame buffer; FRAME_OVERRUN_DETECT_EN adds the sticky overrun flag
module mt9d111_frame_wr_ctrl
  import mt9d111_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES = V_LINES_DEF,
  parameter int BYTES_PER_PIXEL = BYTES_PER_PIXEL_DEF
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic [31:0] fb_start_address,
  input  logic        init_done,
  input  logic        one_shot_state,
  input  logic        one_shot_trigger,
  input  logic        sof,
  input  logic        pix_valid,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic        frame_done,
  output logic        busy
`ifdef FRAME_OVERRUN_DETECT_EN
  ,
  output logic        overrun
`endif
);
  localparam int TOTAL = H_PIXELS * V_LINES;
  localparam int CW = $clog2(TOTAL + 1);
  state_t state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [CW-1:0] count_q, count_d;
  logic arm_q, arm_d, done_q, done_d, trig_rise, last_pix;
`ifdef FRAME_OVERRUN_DETECT_EN
  logic ov_q, ov_d;
  assign overrun = ov_q;
`endif
  mt9d111_pulse_edge u_trig_edge (
    .aclk  (aclk),
    .reset (reset),
    .sig_i (one_shot_trigger),
    .rise_o(trig_rise)
  );
  assign busy = state_q == CAPTURE;
  assign wr_en = busy & pix_valid;
  assign wr_addr = base_q + 32'(count_q) * 32'(BYTES_PER_PIXEL);
  assign last_pix = wr_en & (count_q == CW'(TOTAL - 1));
  assign frame_done = done_q;
  // state, base, count and arm registers
  always_ff @(posedge aclk or posedge reset)
    if (reset) begin
      state_q <= WAIT_INIT;
      base_q  <= '0;
      count_q <= '0;
      arm_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef FRAME_OVERRUN_DETECT_EN
      ov_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      arm_q   <= arm_d;
      done_q  <= done_d;
`ifdef FRAME_OVERRUN_DETECT_EN
      ov_q    <= ov_d;
`endif
    end
  // next state; a frame-completing pixel takes priority over a coincident sof
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    count_d = count_q;
    done_d = 1'b0;
    arm_d = arm_q | (trig_rise & (state_q != WAIT_INIT));
`ifdef FRAME_OVERRUN_DETECT_EN
    ov_d = ov_q;
`endif
    case (state_q)
      WAIT_INIT: state_d = init_done ? WAIT_SOF : WAIT_INIT;
      WAIT_SOF:
        if (sof && (!one_shot_state || arm_q)) begin
          state_d = CAPTURE;
          base_d = fb_start_address;
          count_d = '0;
          arm_d = trig_rise;
        end
      CAPTURE:
        if (last_pix) begin
          done_d = 1'b1;
          count_d = count_q + CW'(1);
          state_d = one_shot_state ? HOLD : WAIT_SOF;
        end else begin
          count_d = pix_valid ? count_q + CW'(1) : count_q;
`ifdef FRAME_OVERRUN_DETECT_EN
          if (sof) begin
            ov_d = 1'b1;
            base_d = fb_start_address;
            count_d = '0;
          end
`endif
        end
      HOLD: state_d = (arm_q || !one_shot_state) ? WAIT_SOF : HOLD;
      default: state_d = WAIT_INIT;
    endcase
  end
endmodule

// File: doc/mt9d111_frame_wr_ctrl.md
MT9D111_FRAME_WR_CTRL -- requirements
Module: mt9d111_frame_wr_ctrl

Interface
REQ-001 Parameter H_PIXELS, default 800, active pixels per line.
REQ-002 Parameter V_LINES, default 600, active lines per frame.
REQ-003 Parameter BYTES_PER_PIXEL, default 4, address increment per accepted pixel.
REQ-004 Port aclk, input, 1, sole clock; all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port fb_start_address, input, 32, frame buffer base byte address.
REQ-007 Port init_done, input, 1, base address has been programmed.
REQ-008 Port one_shot_state, input, 1, 1 = one-shot mode (hold last frame), 0 = continuous.
REQ-009 Port one_shot_trigger, input, 1, multi-cycle pulse requesting one frame capture.
REQ-010 Port sof, input, 1, one-cycle start-of-frame strobe from the camera sync stage.
REQ-011 Port pix_valid, input, 1, one pixel available this cycle.
REQ-012 Port wr_en, output, 1, write one pixel to memory this cycle.
REQ-013 Port wr_addr, output, 32, byte address for the wr_en pixel.
REQ-014 Port frame_done, output, 1, one-cycle pulse after the last pixel of a captured frame.
REQ-015 Port busy, output, 1, high while in CAPTURE.
REQ-016 Port overrun, output, 1, sticky overrun flag; present only when the macro in REQ-031 is defined.

Function
REQ-017 States SHALL be WAIT_INIT, WAIT_SOF, CAPTURE and HOLD.
REQ-018 WAIT_INIT -> WAIT_SOF when init_done=1.
REQ-019 WAIT_SOF -> CAPTURE on sof=1 if one_shot_state=0 or arm=1; the FSM SHALL latch fb_start_address into base, clear the pixel count and clear arm.
REQ-020 In CAPTURE, each pix_valid=1 SHALL assert wr_en in the same cycle (combinational from pix_valid and state) with wr_addr=base+count*BYTES_PER_PIXEL, then increment count.
REQ-021 Address arithmetic is 32-bit modulo 2^32; wrap-around is not flagged.
REQ-022 Count width SHALL be clog2(H_PIXELS*V_LINES+1).
REQ-023 On the pix_valid that makes count = H_PIXELS*V_LINES, frame_done SHALL pulse on the next cycle; the FSM -> HOLD if one_shot_state=1, else -> WAIT_SOF.
REQ-024 pix_valid outside CAPTURE SHALL be ignored (wr_en=0).
REQ-025 arm SHALL set on a rising edge of one_shot_trigger in any state except WAIT_INIT; repeated high cycles of the same pulse set it once.
REQ-026 HOLD -> WAIT_SOF when arm=1 or one_shot_state=0.
REQ-027 When sof and the final pixel occur in the same cycle, the pixel SHALL be written and the frame completed; that sof is not used to start a new frame.
REQ-028 fb_start_address changes SHALL take effect only at the next frame start; the base is stable within a frame.

Reset
REQ-029 Asynchronous reset SHALL set: state WAIT_INIT, base 0, count 0, arm 0, frame_done 0, overrun 0; wr_en=0 and busy=0 follow from the state.
REQ-030 Reset asserted mid-CAPTURE SHALL abort the frame immediately, with no frame_done.

Configuration
REQ-031 Macro FRAME_OVERRUN_DETECT_EN: when defined, sof in CAPTURE before completion SHALL set overrun (sticky until reset), re-latch base and restart count at 0.
REQ-032 Without FRAME_OVERRUN_DETECT_EN, sof in CAPTURE SHALL be ignored and the overrun port SHALL be absent.

Structure
REQ-033 The state encoding and the default H/V/BPP constants SHALL reside in shared package mt9d111_pkg.
REQ-034 A sub-module mt9d111_pulse_edge (rising-edge detector) SHALL generate the one_shot_trigger edge.

Verification
REQ-035 H=4, V=2, base 0x1A000000, continuous mode: sof then 8 pix_valid -> wr_addr 0x1A000000..0x1A00001C, frame_done one cycle after the 8th pixel, then WAIT_SOF.
REQ-036 one_shot_state=1: frame captured -> HOLD, later sof/pix_valid gives no wr_en; a 20-cycle trigger pulse -> exactly one further frame, then HOLD.
REQ-037 Base 0xFFFFFFF8 with 4 pixels -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-038 Macro defined: sof after 3 pixels -> overrun=1, next write at base+0; macro undefined: same stimulus -> frame completes after 8 pixels.
REQ-039 Reset after 5 pixels -> wr_en=0 and busy=0 immediately, no frame_done; capture waits for init_done then sof.
